// File: rtl/cim_result_collector.sv
// Collects per-stack CIM results on done rising edges and serialises them into a show-ahead FIFO.
// Optional build macro CIM_COLLECTOR_PARITY_EN adds a stored even-parity bit per FIFO entry (out_parity).
module cim_result_collector #(
    parameter int NUM_STACKS = 8,
    parameter int DATA_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [NUM_STACKS-1:0]            done,
    input  logic [NUM_STACKS*DATA_W-1:0]     stage_4_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [$clog2(NUM_STACKS)-1:0]    out_stack_id,
    output logic [NUM_STACKS-1:0]            overflow,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
`ifdef CIM_COLLECTOR_PARITY_EN
    ,
    output logic                             out_parity
`endif
);

    localparam int ID_W  = $clog2(NUM_STACKS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int ENT_W = ID_W + DATA_W;

    logic [NUM_STACKS-1:0] done_q;
    logic [NUM_STACKS-1:0] pend_q, pend_d;
    logic [NUM_STACKS-1:0] ovf_q, ovf_d;
    logic [NUM_STACKS-1:0] cap_rise;
    logic [NUM_STACKS-1:0] load;
    logic [DATA_W-1:0]     slot_q [NUM_STACKS];

    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       scan_idx;
    logic                  gnt_vld;

    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    assign cap_rise  = done & ~done_q;
    assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready & ~clear;
    assign push      = gnt_vld;

    // Round-robin search starting at rr_q; a full FIFO only accepts when it pops in the same cycle.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_STACKS; k++) begin
            scan_idx = ID_W'((int'(rr_q) + k) % NUM_STACKS);
            if (!gnt_vld && pend_q[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (clear || (fifo_full && !out_ready)) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (clear) begin
            rr_d = '0;
        end else if (gnt_vld) begin
            rr_d = (gnt_idx == ID_W'(NUM_STACKS - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // A capture into a slot that is being granted this cycle refills it instead of overflowing.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        load   = '0;
        if (gnt_vld) begin
            pend_d[gnt_idx] = 1'b0;
        end
        for (int i = 0; i < NUM_STACKS; i++) begin
            if (cap_rise[i]) begin
                if (!pend_q[i] || (gnt_vld && gnt_idx == ID_W'(i))) begin
                    pend_d[i] = 1'b1;
                    load[i]   = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
        if (clear) begin
            pend_d = '0;
            ovf_d  = '0;
            load   = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            rr_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            done_q <= done;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            if (clear) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + AW'(1);
                if (pop)  rd_q <= rd_q + AW'(1);
            end
        end
    end

    // Data storage carries no reset; visibility is controlled by pend_q and cnt_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            if (load[i]) slot_q[i] <= stage_4_out[i*DATA_W +: DATA_W];
        end
        if (push) mem_q[wr_q] <= {gnt_idx, slot_q[gnt_idx]};
    end

    assign {out_stack_id, out_data} = out_valid ? mem_q[rd_q] : '0;
    assign overflow   = ovf_q;
    assign fifo_count = cnt_q;

`ifdef CIM_COLLECTOR_PARITY_EN
    logic par_q [FIFO_DEPTH];

    function automatic logic even_parity(input logic [ENT_W-1:0] ent);
        return ^ent;
    endfunction

    always_ff @(posedge clk) begin
        if (push) par_q[wr_q] <= even_parity({gnt_idx, slot_q[gnt_idx]});
    end

    assign out_parity = out_valid ? par_q[rd_q] : 1'b0;
`endif

endmodule

// File: tb/tb_cim_result_collector.sv
// Directed-vector bench for cim_result_collector (default parameters).
// Define CIM_COLLECTOR_PARITY_EN for both files to exercise the parity output.
module tb_cim_result_collector;

    logic          clk;
    logic          reset;
    logic          clear;
    logic [7:0]    done;
    logic [175:0]  stage_4_out;
    logic          out_valid;
    logic          out_ready;
    logic [21:0]   out_data;
    logic [2:0]    out_stack_id;
    logic [7:0]    overflow;
    logic [2:0]    fifo_count;
`ifdef CIM_COLLECTOR_PARITY_EN
    logic          out_parity;
`endif

    int n_total = 0;
    int n_bad   = 0;

    cim_result_collector #(.NUM_STACKS(8), .DATA_W(22), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .done         (done),
        .stage_4_out  (stage_4_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_stack_id (out_stack_id),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
`ifdef CIM_COLLECTOR_PARITY_EN
        ,
        .out_parity   (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [21:0] v);
        stage_4_out[i*22 +: 22] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stall;
        logic [24:0] prev;
        int          exp_id [5];
        logic [21:0] exp_dat [5];

        reset       = 1'b0;
        clear       = 1'b0;
        done        = '0;
        stage_4_out = '0;
        out_ready   = 1'b0;

        // reset state
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_id", 64'(out_stack_id), 64'd0);
`ifdef CIM_COLLECTOR_PARITY_EN
        check("rst_par", 64'(out_parity), 64'd0);
`endif
        tick();
        reset = 1'b1;
        tick();

        // single capture on stack 3, one-cycle latency, held done captures once
        out_ready = 1'b1;
        set_slot(3, 22'h2A5F0);
        done = 8'h08;
        tick();
        check("t1_early_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h2A5F0);
        check("t1_id", 64'(out_stack_id), 64'd3);
        check("t1_count", 64'(fifo_count), 64'd1);
        tick();
        check("t1_popped_valid", 64'(out_valid), 64'd0);
        check("t1_popped_count", 64'(fifo_count), 64'd0);
        tick();
        check("t1_held_done", 64'(out_valid), 64'd0);
        done = '0;
        do_clear();

        // all eight stacks at once with a stalled consumer
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) set_slot(i, 22'(22'h100 + i));
        done = 8'hFF;
        repeat (5) tick();
        check("t2_full_count", 64'(fifo_count), 64'd4);
        check("t2_head_id", 64'(out_stack_id), 64'd0);
        check("t2_head_data", 64'(out_data), 64'h100);
        repeat (3) tick();
        check("t2_hold_count", 64'(fifo_count), 64'd4);
        check("t2_hold_id", 64'(out_stack_id), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_drain_valid", 64'(out_valid), 64'd1);
            check("t2_drain_id", 64'(out_stack_id), 64'(k));
            check("t2_drain_data", 64'(out_data), 64'(22'h100 + k));
            tick();
        end
        check("t2_empty", 64'(out_valid), 64'd0);
        check("t2_ovf", 64'(overflow), 64'd0);
        done = '0;
        do_clear();

        // slot 5 blocked by a full FIFO captures twice: second result dropped
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_slot(i, 22'(22'h200 + i));
        done = 8'h0F;
        repeat (5) tick();
        check("t3_full", 64'(fifo_count), 64'd4);
        set_slot(5, 22'h15555);
        done = 8'h20;
        tick();
        done = 8'h00;
        tick();
        set_slot(5, 22'h0AAAA);
        done = 8'h20;
        tick();
        check("t3_ovf", 64'(overflow), 64'h20);
        check("t3_count", 64'(fifo_count), 64'd4);
        exp_id  = '{0, 1, 2, 3, 5};
        exp_dat = '{22'h200, 22'h201, 22'h202, 22'h203, 22'h15555};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t3_drain_id", 64'(out_stack_id), 64'(exp_id[k]));
            check("t3_drain_data", 64'(out_data), 64'(exp_dat[k]));
            tick();
        end
        check("t3_no_second", 64'(out_valid), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'h20);
        done = '0;
        do_clear();
        check("t3_ovf_cleared", 64'(overflow), 64'd0);

        // backpressure: ready toggles under a stream of one capture per cycle
        for (int c = 0; c < 24; c++) begin
            done = 8'h01 << (c % 8);
            set_slot(c % 8, 22'(22'h300 + c));
            out_ready = c[0];
            stall = out_valid && !out_ready;
            prev  = {out_stack_id, out_data};
            tick();
            if (stall) check("t4_stall_hold", 64'({out_stack_id, out_data}), 64'(prev));
            check("t4_cnt_max", 64'(fifo_count <= 3'd4), 64'd1);
        end
        done = '0;
        out_ready = 1'b1;
        repeat (16) tick();
        check("t4_drained", 64'(out_valid), 64'd0);
        do_clear();

        // asynchronous reset with three queued and two pending entries
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) set_slot(i, 22'(22'h400 + i));
        done = 8'h1F;
        repeat (4) tick();
        check("t5_queued", 64'(fifo_count), 64'd3);
        #3;
        reset = 1'b0;
        #1;
        check("t5_async_valid", 64'(out_valid), 64'd0);
        check("t5_async_count", 64'(fifo_count), 64'd0);
        check("t5_async_data", 64'(out_data), 64'd0);
        done = '0;
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        check("t5_post_valid", 64'(out_valid), 64'd0);
        check("t5_post_count", 64'(fifo_count), 64'd0);

        // done already high at reset release counts as a new capture
        reset = 1'b0;
        set_slot(2, 22'h777);
        done = 8'h04;
        tick();
        reset = 1'b1;
        tick();
        check("t6_capture_wait", 64'(out_valid), 64'd0);
        tick();
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_id", 64'(out_stack_id), 64'd2);
        check("t6_data", 64'(out_data), 64'h777);
        tick();
        check("t6_popped", 64'(out_valid), 64'd0);

`ifdef CIM_COLLECTOR_PARITY_EN
        out_ready = 1'b0;
        set_slot(1, 22'h000003);
        done = 8'h02;
        tick();
        tick();
        check("par_valid", 64'(out_valid), 64'd1);
        check("par_bit", 64'(out_parity), 64'd1);
        done = '0;
        do_clear();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_result_collector.md
CIM_RESULT_COLLECTOR -- requirements
Module: cim_result_collector

Interface
REQ-001 SHALL have parameter NUM_STACKS, default 8: number of CIM stacks feeding the collector.
REQ-002 SHALL have parameter DATA_W, default 22: width of each stack's stage-4 result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of all pending entries, FIFO contents and overflow flags.
REQ-007 SHALL have port done, input, NUM_STACKS bits: per-stack completion level from the stacks.
REQ-008 SHALL have port stage_4_out, input, NUM_STACKS x DATA_W bits: per-stack results, valid while that stack's done is high.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data and out_stack_id hold a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the entry.
REQ-011 SHALL have port out_data, output, DATA_W bits: result at the FIFO head.
REQ-012 SHALL have port out_stack_id, output, $clog2(NUM_STACKS) bits: index of the originating stack.
REQ-013 SHALL have port overflow, output, NUM_STACKS bits: sticky per-stack lost-result flags.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 SHALL register done into done_q and capture stage_4_out[i] into pending slot i on the edge where done[i]=1 and done_q[i]=0; a held-high done captures once.
REQ-016 SHALL set overflow[i], keep the old pending data and drop the new result when a capture occurs while slot i is pending and slot i is not granted in that cycle.
REQ-017 SHALL, when capture and grant hit the same slot in the same cycle, move the old data to the FIFO and load the new data into the slot, with overflow unchanged.
REQ-018 SHALL grant at most one pending slot per cycle, round-robin, starting the search at the index after the last granted one; the pointer resets to search from slot 0.
REQ-019 SHALL grant only when the FIFO is not full, or is full and out_ready=1 in that cycle (simultaneous push and pop allowed).
REQ-020 SHALL write {stack index, data} into the FIFO on the granting edge and clear the granted slot's pending bit.
REQ-021 SHALL drive out_valid=1 whenever the FIFO is non-empty, with out_data and out_stack_id taken combinationally from the FIFO head (show-ahead).
REQ-022 SHALL pop the FIFO on an edge with out_valid=1 and out_ready=1; out_data and out_stack_id SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL have a minimum latency from the capture edge to out_valid=1 of exactly 1 cycle.
REQ-024 SHALL keep fifo_count exact under a simultaneous push and pop; it never exceeds FIFO_DEPTH and never underflows.
REQ-025 SHALL, when clear=1, empty the FIFO, clear all pending bits and overflow flags, and reset the round-robin pointer; clear SHALL take priority over capture, grant and pop in the same cycle, and done_q still updates.

Reset
REQ-026 SHALL, while reset=0, asynchronously force out_valid=0, fifo_count=0, overflow=0, all pending bits=0, done_q=0, pointer=0 and FIFO read/write pointers=0; out_data and out_stack_id SHALL read 0.
REQ-027 SHALL treat a stack whose done is already high at reset release as a new capture on the first edge after release.
REQ-028 SHALL, on reset mid-operation, discard pending and FIFO contents with no output handshake.

Configuration
REQ-029 SHALL, with CIM_COLLECTOR_PARITY_EN defined, add output out_parity (1 bit), equal to the even parity of {out_stack_id, out_data}, computed at FIFO write and stored per entry; out_parity SHALL be 0 in reset.
REQ-030 SHALL, without CIM_COLLECTOR_PARITY_EN, have no out_parity port and no parity storage, with all other behaviour identical.

Verification
REQ-031 Single capture: done[3] rises with data 0x2A5F0, out_ready=1 -> one cycle later out_valid=1, out_data=0x2A5F0, out_stack_id=3; popped; fifo_count returns to 0.
REQ-032 All 8 done rise together, out_ready=0, FIFO_DEPTH=4 -> FIFO fills with ids 0,1,2,3; ids 4-7 stay pending; raising out_ready delivers ids 0..7 in order with no loss.
REQ-033 done[5] pulses twice while slot 5 is blocked by a full FIFO -> overflow[5]=1, first value delivered, second dropped; clear -> overflow=0.
REQ-034 Backpressure: out_ready toggles 1/0 each cycle under a continuous capture stream -> data stable while stalled, fifo_count never exceeds 4.
REQ-035 Assert reset=0 with 3 entries queued and 2 pending -> out_valid=0 immediately (asynchronous); nothing emitted after release until new done edges.
REQ-036 With CIM_COLLECTOR_PARITY_EN, id=1 and data=0x000003 -> out_parity=1.
